// File: rtl/thor2022_io_bridge.sv
// Bridge from the 128-bit CPU bus to NSLV 32-bit I/O slaves: decodes page/slot,
// splits multi-lane accesses into 32-bit sub-transfers and merges the read data.
module thor2022_io_bridge #(
    parameter int          NSLV    = 4,
    parameter logic [15:0] IO_PAGE = 16'hFF96,
    parameter int          TIMEOUT = 63
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [15:0]          m_sel_i,
    input  logic [31:0]          m_adr_i,
    input  logic [127:0]         m_dat_i,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic [127:0]         m_dat_o,
    output logic [NSLV-1:0]      s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [NSLV*32-1:0]   s_dat_i,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XFER = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4,
        S_REL  = 3'd5
    } state_t;

    localparam logic [4:0] NSLV_W = 5'(NSLV);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t         r_state, w_next;
    logic           r_we, w_we_nx;
    logic [31:4]    r_adr, w_adr_nx;
    logic [127:0]   r_dat, w_dat_nx;
    logic [15:0]    r_sel, w_sel_nx;
    logic [3:0]     r_slot, w_slot_nx;
    logic [3:0]     r_lanes, w_lanes_nx;
    logic [1:0]     r_lane, w_lane_nx;
    logic [7:0]     r_cnt, w_cnt_nx;
    logic [127:0]   r_rdat, w_rdat_nx;

    logic           w_hit;
    logic           w_unmapped;
    logic [3:0]     w_mask;
    logic [3:0]     w_rem;
    logic           w_ack;
    logic [31:0]    w_sdat;
    logic           w_xfer;
    logic [3:0]     w_lsel;
    logic [31:0]    w_ldat;
    logic           w_unused_adr;

    assign w_unused_adr = ^m_adr_i[3:0];

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) l = 2'(i);
        end
        return l;
    endfunction

    assign w_hit      = m_cyc_i && m_stb_i && (m_adr_i[31:16] == IO_PAGE);
    assign w_unmapped = {1'b0, m_adr_i[15:12]} >= NSLV_W;
    assign w_mask     = {|m_sel_i[15:12], |m_sel_i[11:8], |m_sel_i[7:4], |m_sel_i[3:0]};
    assign w_rem      = r_lanes & ~(4'b0001 << r_lane);

    // Only the latched slot's ack and data are visible; other slaves are ignored.
    always_comb begin
        w_ack  = 1'b0;
        w_sdat = 32'h0;
        for (int n = 0; n < NSLV; n++) begin
            if (r_slot == 4'(n)) begin
                w_ack  = s_ack_i[n];
                w_sdat = s_dat_i[32*n +: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_slot  <= '0;
            r_lanes <= '0;
            r_lane  <= '0;
            r_cnt   <= '0;
            r_rdat  <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= w_we_nx;
            r_adr   <= w_adr_nx;
            r_dat   <= w_dat_nx;
            r_sel   <= w_sel_nx;
            r_slot  <= w_slot_nx;
            r_lanes <= w_lanes_nx;
            r_lane  <= w_lane_nx;
            r_cnt   <= w_cnt_nx;
            r_rdat  <= w_rdat_nx;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_we_nx    = r_we;
        w_adr_nx   = r_adr;
        w_dat_nx   = r_dat;
        w_sel_nx   = r_sel;
        w_slot_nx  = r_slot;
        w_lanes_nx = r_lanes;
        w_lane_nx  = r_lane;
        w_cnt_nx   = r_cnt;
        w_rdat_nx  = r_rdat;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_we_nx   = m_we_i;
                    w_adr_nx  = m_adr_i[31:4];
                    w_dat_nx  = m_dat_i;
                    w_sel_nx  = m_sel_i;
                    w_slot_nx = m_adr_i[15:12];
                    w_rdat_nx = '0;
                    if (w_mask == 4'b0000) begin
                        w_next = S_DONE;
                    end else if (w_unmapped) begin
                        w_next = S_ERR;
                    end else begin
                        w_lanes_nx = w_mask;
                        w_lane_nx  = lowest(w_mask);
                        w_cnt_nx   = '0;
                        w_next     = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (!m_cyc_i) begin
                    w_next = S_IDLE;
                end else if (w_ack) begin
                    // Ack is checked before the timeout so a last-cycle ack still completes.
                    if (!r_we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (r_lane == 2'(k)) w_rdat_nx[32*k +: 32] = w_sdat;
                        end
                    end
                    w_lanes_nx = w_rem;
                    w_next     = (w_rem != 4'b0000) ? S_GAP : S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_lanes_nx = '0;
                    w_rdat_nx  = '0;
                    w_next     = S_ERR;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (!m_cyc_i) begin
                    w_next = S_IDLE;
                end else begin
                    w_lane_nx = lowest(r_lanes);
                    w_cnt_nx  = '0;
                    w_next    = S_XFER;
                end
            end
            S_DONE: w_next = S_REL;
            S_ERR: begin
                w_rdat_nx = '0;
                w_next    = S_REL;
            end
            S_REL: begin
                if (!m_stb_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Slave-side and master-side outputs are decoded from registered state only.
    always_comb begin
        w_xfer = (r_state == S_XFER);
        w_lsel = 4'h0;
        w_ldat = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (r_lane == 2'(k)) begin
                w_lsel = r_sel[4*k +: 4];
                w_ldat = r_dat[32*k +: 32];
            end
        end
        for (int n = 0; n < NSLV; n++) begin
            s_cyc_o[n] = w_xfer && (r_slot == 4'(n));
        end
        s_stb_o     = w_xfer;
        s_we_o      = w_xfer && r_we;
        s_sel_o     = w_xfer ? w_lsel : 4'h0;
        s_dat_o     = w_xfer ? w_ldat : 32'h0;
        s_adr_o     = w_xfer ? {r_adr, r_lane, 2'b00} : 32'h0;
        m_ack_o     = (r_state == S_DONE);
        m_err_o     = (r_state == S_ERR);
        m_dat_o     = r_rdat;
        dbg_state_o = r_state;
    end

endmodule

// File: tb/tb_thor2022_io_bridge.sv
// Directed, table-driven bench for thor2022_io_bridge (NSLV=4, TIMEOUT=63)
// with hand-written sequences for reset, abort, sel=0 and non-hit cases.
module tb_thor2022_io_bridge;

  logic          clk;
  logic          rst_ni;
  logic          m_cyc_i, m_stb_i, m_we_i;
  logic [15:0]   m_sel_i;
  logic [31:0]   m_adr_i;
  logic [127:0]  m_dat_i;
  logic          m_ack_o, m_err_o;
  logic [127:0]  m_dat_o;
  logic [3:0]    s_cyc_o;
  logic          s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_ack_i;
  logic [127:0]  s_dat_i;
  logic [2:0]    dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [67:0] exp_q[$];

  thor2022_io_bridge #(.NSLV(4), .IO_PAGE(16'hFF96), .TIMEOUT(63)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i),
    .s_dat_i(s_dat_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] wdat;
    logic [127:0] rimg;
    int           lat;       // stb cycles before ack; -1 = never ack
    logic         noise;     // non-selected slaves hold ack high
    logic         exp_ack;
    logic         exp_err;
    logic [127:0] exp_dat;
    int           exp_k;     // cycles from request to response
    int           exp_nsub;
    int           exp_stb;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_master();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_sel_i = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    s_ack_i = '0;
    s_dat_i = '0;
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o});
  endfunction

  // driver + slave responder + scoreboard for one master access
  task automatic run_txn(input vec_t v);
    int k, cnt, nsub, nstb, resp, lowrun, proto_bad;
    logic ackme, got_ack, got_err;
    logic [127:0] got_dat;
    logic [3:0] slot;
    logic [3:0] exp_cyc;
    logic [67:0] e;
    slot = v.adr[15:12];
    exp_cyc = 4'b0001 << slot[1:0];
    exp_q.delete();
    for (int l = 0; l < 4; l++) begin
      if (v.sel[4*l +: 4] != 4'h0)
        exp_q.push_back({v.adr[31:4], 2'(l), 2'b00, v.sel[4*l +: 4], v.wdat[32*l +: 32]});
    end
    m_we_i = v.we; m_sel_i = v.sel; m_adr_i = v.adr; m_dat_i = v.wdat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    k = 0; cnt = 0; nsub = 0; nstb = 0; resp = -1; lowrun = 0; proto_bad = 0;
    got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    while (k < 400 && resp < 0) begin
      step();
      k++;
      ackme = 1'b0;
      if ((s_cyc_o != 4'h0) != s_stb_o) proto_bad++;
      if (m_ack_o || m_err_o) begin
        resp = k; got_ack = m_ack_o; got_err = m_err_o; got_dat = m_dat_o;
      end else if (s_stb_o) begin
        cnt++; nstb++;
        if (cnt == 1) begin
          nsub++;
          if (nsub > 1 && lowrun != 1) proto_bad++;
          chk({v.name, ".cyc"}, 256'({s_cyc_o, s_we_o}), 256'({exp_cyc, v.we}));
          if (exp_q.size() == 0) begin
            chk({v.name, ".extra_sub"}, 256'(1), 256'(0));
          end else begin
            e = exp_q.pop_front();
            chk({v.name, ".sub"}, 256'({s_adr_o, s_sel_o, v.we ? s_dat_o : 32'h0}),
                256'({e[67:36], e[35:32], v.we ? e[31:0] : 32'h0}));
          end
        end
        lowrun = 0;
        ackme = (v.lat >= 0) && (cnt == v.lat + 1);
      end else begin
        cnt = 0;
        lowrun++;
      end
      for (int n = 0; n < 4; n++) begin
        if (4'(n) == slot) begin
          s_ack_i[n] = ackme && (resp < 0);
          s_dat_i[32*n +: 32] = v.rimg[32*int'(s_adr_o[3:2]) +: 32];
        end else begin
          s_ack_i[n] = v.noise;
          s_dat_i[32*n +: 32] = 32'hBAD0_0000 + 32'(n);
        end
      end
    end
    if (resp < 0) chk({v.name, ".no_response"}, 256'(0), 256'(1));
    chk({v.name, ".resp_cycle"}, 256'(resp), 256'(v.exp_k));
    chk({v.name, ".ack_err"}, 256'({got_ack, got_err}), 256'({v.exp_ack, v.exp_err}));
    chk({v.name, ".m_dat"}, 256'(got_dat), 256'(v.exp_dat));
    chk({v.name, ".nsub"}, 256'(nsub), 256'(v.exp_nsub));
    chk({v.name, ".stb_cycles"}, 256'(nstb), 256'(v.exp_stb));
    chk({v.name, ".protocol"}, 256'(proto_bad), 256'(0));
    s_ack_i = '0;
    step();
    chk({v.name, ".one_pulse"}, 256'({m_ack_o, m_err_o, s_stb_o}), 256'(0));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();
    step();
    exp_q.delete();
  endtask

  initial begin
    logic acc;
    vecs[0] = '{"rd_single", 1'b0, 16'h00F0, 32'hFF961004, 128'h0,
                {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 2, 1'b0, 1'b1, 1'b0,
                128'h00000000_00000000_DEADBEEF_00000000, 4, 1, 3};
    vecs[1] = '{"wr_full", 1'b1, 16'hFFFF, 32'hFF960000,
                128'h44444444_33333333_22222222_11111111, 128'h0, 0, 1'b0, 1'b1, 1'b0,
                128'h0, 8, 4, 4};
    vecs[2] = '{"rd_lanes02_noise", 1'b0, 16'h0F0F, 32'hFF963008, 128'h0,
                128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 1, 1'b1, 1'b1, 1'b0,
                128'h00000000_AAAA0002_00000000_AAAA0000, 6, 2, 4};
    vecs[3] = '{"unmapped", 1'b0, 16'hFFFF, 32'hFF96F000, 128'h0, 128'h0, 0, 1'b0,
                1'b0, 1'b1, 128'h0, 1, 0, 0};
    vecs[4] = '{"sel_zero", 1'b0, 16'h0000, 32'hFF962000, 128'h0, 128'h0, 0, 1'b0,
                1'b1, 1'b0, 128'h0, 1, 0, 0};
    vecs[5] = '{"wr_lane3_noise", 1'b1, 16'hF000, 32'hFF962000,
                128'hCAFEF00D_BBBBBBBB_CCCCCCCC_DDDDDDDD, 128'h0, 3, 1'b1, 1'b1, 1'b0,
                128'h0, 5, 1, 4};
    vecs[6] = '{"rd_full", 1'b0, 16'hFFFF, 32'hFF961000, 128'h0,
                128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 1'b0, 1'b1, 1'b0,
                128'h01234567_89ABCDEF_FEDCBA98_76543210, 8, 4, 4};
    vecs[7] = '{"timeout", 1'b0, 16'hFFFF, 32'hFF962000, 128'h0,
                128'h11111111_22222222_33333333_44444444, -1, 1'b0, 1'b0, 1'b1,
                128'h0, 64, 1, 63};
    vecs[8] = '{"ack_at_timeout", 1'b0, 16'h000F, 32'hFF960000, 128'h0,
                128'h0_0000000_00000000_00000000_5A5AA5A5, 62, 1'b0, 1'b1, 1'b0,
                128'h00000000_00000000_00000000_5A5AA5A5, 64, 1, 63};

    idle_master();
    rst_ni = 1'b0;
    step();
    step();
    chk("reset.outputs", all_outs(), 256'(0));
    chk("reset.state", 256'(dbg_state_o), 256'(0));
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // sel=0 hit with strobe held: exactly one ack until stb drops
    m_sel_i = 16'h0; m_adr_i = 32'hFF960000; m_we_i = 1'b0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step();
    chk("sel0.ack", 256'({m_ack_o, m_err_o, s_cyc_o}), 256'({1'b1, 1'b0, 4'h0}));
    chk("sel0.dat", 256'(m_dat_o), 256'(0));
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc = acc | m_ack_o | m_err_o | s_stb_o;
    end
    chk("sel0.held_no_second_ack", 256'(acc), 256'(0));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();
    chk("sel0.after_drop", 256'({m_ack_o, m_err_o}), 256'(0));
    step();

    // reset during the XFER of lane 1
    m_we_i = 1'b1; m_sel_i = 16'hFFFF; m_adr_i = 32'hFF961000;
    m_dat_i = 128'h44444444_33333333_22222222_11111111;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step();
    chk("rst_mid.lane0", 256'({s_stb_o, s_adr_o, s_dat_o}), 256'({1'b1, 32'hFF961000, 32'h11111111}));
    s_ack_i = 4'b0010;
    step();
    s_ack_i = 4'b0000;
    chk("rst_mid.gap", 256'({s_stb_o, s_cyc_o}), 256'(0));
    step();
    chk("rst_mid.lane1", 256'({s_stb_o, s_cyc_o, s_adr_o}), 256'({1'b1, 4'b0010, 32'hFF961004}));
    rst_ni = 1'b0;
    step();
    chk("rst_mid.outputs", all_outs(), 256'(0));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    rst_ni = 1'b1;
    step();
    vecs[0].name = "rst_mid.fresh";
    run_txn(vecs[0]);

    // master abort while waiting for a slave
    m_we_i = 1'b0; m_sel_i = 16'h00FF; m_adr_i = 32'hFF961000;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    step();
    step();
    chk("abort.stb_before", 256'({s_stb_o, s_cyc_o}), 256'({1'b1, 4'b0010}));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();
    chk("abort.dropped", 256'({s_stb_o, s_cyc_o, m_ack_o, m_err_o}), 256'(0));
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | m_ack_o | m_err_o | s_stb_o;
    end
    chk("abort.quiet", 256'(acc), 256'(0));
    vecs[2].name = "abort.recover";
    run_txn(vecs[2]);

    // access outside the I/O page is ignored
    m_sel_i = 16'hFFFF; m_adr_i = 32'hFF970000;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | m_ack_o | m_err_o | s_stb_o;
    end
    chk("nonhit.ignored", 256'(acc), 256'(0));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
